change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Return-side counterpart of the vending machine FSM's coin intake. The FSM accepts coins and computes change; this block pays that change back out.
- Accepts one change amount per transaction. Breaks it into 10/5/1 coins, largest coin first, within available coin stock.
- Presents coins one at a time to the coin hopper over a valid/ready handshake.
- Sits between the FSM's `change` output and the physical coin hopper interface.

Parameters:
- INIT_TEN, 16, number of 10-dollar coins loaded at reset
- INIT_FIVE, 16, number of 5-dollar coins loaded at reset
- STOCK_W, 16, width of the stock counters. 1-dollar coins are unlimited.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- change_valid  in  1  change request from FSM, qualifies change_amount
- change_amount  in  32  dollars to return, unsigned
- change_ready  out  1  high in IDLE; request accepted when change_valid && change_ready
- coin_valid  out  1  coin_value is presented to the hopper
- coin_value  out  32  10, 5 or 1 while coin_valid; 0 otherwise
- coin_ready  in  1  hopper takes the coin when coin_valid && coin_ready
- done  out  1  one-cycle pulse when the transaction completes
- paid_total  out  32  sum of coins handed over in the current/last transaction
- ten_left  out  STOCK_W  remaining 10-dollar coins
- five_left  out  STOCK_W  remaining 5-dollar coins

Behaviour:
- Reset (reset=0, async) values:
  - state=IDLE, change_ready=1, coin_valid=0, coin_value=0, done=0, paid_total=0
  - ten_left=INIT_TEN, five_left=INIT_FIVE, internal remaining=0
- State IDLE:
  - change_ready=1.
  - On accept: latch remaining=change_amount and clear paid_total=0.
  - If change_amount==0, go to DONE. Otherwise go to PAY.
  - change_valid is ignored in all other states.
- Coin selection (combinational from remaining and stock):
  - 10 if remaining>=10 && ten_left>0
  - else 5 if remaining>=5 && five_left>0
  - else 1
- State PAY:
  - coin_valid=1 and coin_value=the selected coin.
  - First coin appears the cycle after accept (1-cycle latency).
  - coin_value must stay stable while coin_valid && !coin_ready. No coin is skipped or duplicated.
  - On a handshake edge:
    - remaining -= coin_value
    - paid_total += coin_value
    - decrement ten_left or five_left if that denomination was paid
  - After the handshake: if the new remaining==0, go to DONE (coin_valid=0, coin_value=0 next cycle). Otherwise stay in PAY and present the next coin in the very next cycle, so back-to-back coins are allowed.
- State DONE:
  - done=1 for exactly one cycle, change_ready=0, then IDLE.
  - paid_total holds its value until the next accept.
- Invariants:
  - paid_total equals the accepted change_amount at done.
  - Stock counters never underflow; selection never picks a denomination with 0 stock.
- Reset mid-transaction: abort immediately.
  - All outputs return to reset values, including stock reloading to INIT_*.
  - The partially paid amount is lost; the FSM must re-issue the request.
- Arithmetic:
  - remaining and paid_total are 32-bit unsigned. No overflow is possible because paid_total <= change_amount.
  - Stock counters are STOCK_W-bit, decrement only.

Test Plan:
- Reset, then idle: after reset release → change_ready=1, coin_valid=0, done=0, paid_total=0, ten_left=16, five_left=16.
- change_amount=26, coin_ready=1 → coins 10,10,5,1 on 4 consecutive cycles. Then done pulse, paid_total=26, ten_left=14, five_left=15.
- change_amount=6 with coin_ready held low 3 cycles on the first coin → coin_value stays 5 for 4 cycles, then 1, done, paid_total=6.
- INIT_TEN=1, change_amount=25 → coins 10,5,5,5. ten_left=0, five_left=13. A following request of 12 pays 5,5,1,1.
- change_amount=0 → no coin_valid, done the cycle after accept, paid_total=0. change_valid pulsed while in PAY is ignored (no second transaction).
- Assert reset after 2 coins of a 26 request → coin_valid=0 and stock reloaded to 16/16 immediately. A new request of 15 then pays 10,5.

Source files
------------

// File: rtl/change_dispenser.sv
// Pays out a change amount as 10/5/1 coins, largest first, within the 10/5 coin stock.
// Coins go to the hopper one per valid/ready handshake; done pulses once the amount is paid.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | change_ready high, waiting for a change request
// PAY   | presenting the selected coin to the hopper until remaining is 0
// DONE  | one-cycle done pulse, then back to IDLE
module change_dispenser #(
    parameter int unsigned INIT_TEN  = 16,
    parameter int unsigned INIT_FIVE = 16,
    parameter int unsigned STOCK_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               change_valid,
    input  logic [31:0]        change_amount,
    output logic               change_ready,
    output logic               coin_valid,
    output logic [31:0]        coin_value,
    input  logic               coin_ready,
    output logic               done,
    output logic [31:0]        paid_total,
    output logic [STOCK_W-1:0] ten_left,
    output logic [STOCK_W-1:0] five_left
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAY  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] remaining;
    logic [31:0] sel_coin;
    logic        sel_ten;
    logic        sel_five;
    logic        accept;
    logic        handshake;
    logic [31:0] remaining_after;

    // Selection depends only on registered state, so it cannot move while the hopper stalls.
    always_comb begin
        sel_ten  = 1'b0;
        sel_five = 1'b0;
        sel_coin = 32'd1;
        if (remaining >= 32'd10 && ten_left != '0) begin
            sel_ten  = 1'b1;
            sel_coin = 32'd10;
        end else if (remaining >= 32'd5 && five_left != '0) begin
            sel_five = 1'b1;
            sel_coin = 32'd5;
        end
    end

    assign accept          = (state == IDLE) && change_valid;
    assign handshake       = (state == PAY) && coin_ready;
    assign remaining_after = remaining - sel_coin;

    always_comb begin
        state_next   = state;
        change_ready = 1'b0;
        coin_valid   = 1'b0;
        coin_value   = 32'd0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                change_ready = 1'b1;
                if (change_valid) begin
                    state_next = (change_amount == 32'd0) ? DONE : PAY;
                end
            end
            PAY: begin
                coin_valid = 1'b1;
                coin_value = sel_coin;
                if (coin_ready && remaining_after == 32'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining  <= 32'd0;
            paid_total <= 32'd0;
        end else if (accept) begin
            remaining  <= change_amount;
            paid_total <= 32'd0;
        end else if (handshake) begin
            remaining  <= remaining_after;
            paid_total <= paid_total + sel_coin;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ten_left  <= STOCK_W'(INIT_TEN);
            five_left <= STOCK_W'(INIT_FIVE);
        end else if (handshake) begin
            if (sel_ten) begin
                ten_left <= ten_left - STOCK_W'(1);
            end
            if (sel_five) begin
                five_left <= five_left - STOCK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: default-stock instance plus a one-ten-coin instance.
// Inputs are driven and outputs checked on the falling edge.
module tb_change_dispenser;

    logic        clk;
    logic        reset;

    logic        a_change_valid;
    logic [31:0] a_change_amount;
    logic        a_change_ready;
    logic        a_coin_valid;
    logic [31:0] a_coin_value;
    logic        a_coin_ready;
    logic        a_done;
    logic [31:0] a_paid_total;
    logic [15:0] a_ten_left;
    logic [15:0] a_five_left;

    logic        b_change_valid;
    logic [31:0] b_change_amount;
    logic        b_change_ready;
    logic        b_coin_valid;
    logic [31:0] b_coin_value;
    logic        b_coin_ready;
    logic        b_done;
    logic [31:0] b_paid_total;
    logic [15:0] b_ten_left;
    logic [15:0] b_five_left;

    int errors = 0;
    int checks = 0;

    change_dispenser dut_a (
        .clk           (clk),
        .reset         (reset),
        .change_valid  (a_change_valid),
        .change_amount (a_change_amount),
        .change_ready  (a_change_ready),
        .coin_valid    (a_coin_valid),
        .coin_value    (a_coin_value),
        .coin_ready    (a_coin_ready),
        .done          (a_done),
        .paid_total    (a_paid_total),
        .ten_left      (a_ten_left),
        .five_left     (a_five_left)
    );

    change_dispenser #(.INIT_TEN(1)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .change_valid  (b_change_valid),
        .change_amount (b_change_amount),
        .change_ready  (b_change_ready),
        .coin_valid    (b_coin_valid),
        .coin_value    (b_coin_value),
        .coin_ready    (b_coin_ready),
        .done          (b_done),
        .paid_total    (b_paid_total),
        .ten_left      (b_ten_left),
        .five_left     (b_five_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int c26[4];
        int c25[4];
        int c12[4];
        c26 = '{10, 10, 5, 1};
        c25 = '{10, 5, 5, 5};
        c12 = '{5, 5, 1, 1};

        reset = 1'b0;
        a_change_valid = 1'b0; a_change_amount = 32'd0; a_coin_ready = 1'b0;
        b_change_valid = 1'b0; b_change_amount = 32'd0; b_coin_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();

        chk("rst_ready", 32'(a_change_ready), 32'd1);
        chk("rst_cvalid", 32'(a_coin_valid), 32'd0);
        chk("rst_cvalue", a_coin_value, 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_paid", a_paid_total, 32'd0);
        chk("rst_ten", 32'(a_ten_left), 32'd16);
        chk("rst_five", 32'(a_five_left), 32'd16);

        // 26 with hopper always ready: 10,10,5,1 back to back
        a_change_valid = 1'b1; a_change_amount = 32'd26; a_coin_ready = 1'b1;
        tick();
        a_change_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("p26_valid%0d", i), 32'(a_coin_valid), 32'd1);
            chk($sformatf("p26_coin%0d", i), a_coin_value, 32'(c26[i]));
            tick();
        end
        chk("p26_done", 32'(a_done), 32'd1);
        chk("p26_ready_in_done", 32'(a_change_ready), 32'd0);
        chk("p26_cvalid_in_done", 32'(a_coin_valid), 32'd0);
        chk("p26_paid", a_paid_total, 32'd26);
        chk("p26_ten", 32'(a_ten_left), 32'd14);
        chk("p26_five", 32'(a_five_left), 32'd15);
        tick();
        chk("p26_done_low", 32'(a_done), 32'd0);
        chk("p26_idle_ready", 32'(a_change_ready), 32'd1);
        chk("p26_paid_hold", a_paid_total, 32'd26);

        // 6 with hopper stalled for 3 cycles on the first coin
        a_change_valid = 1'b1; a_change_amount = 32'd6; a_coin_ready = 1'b0;
        tick();
        a_change_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("p6_stall%0d", i), a_coin_value, 32'd5);
            chk($sformatf("p6_stall_paid%0d", i), a_paid_total, 32'd0);
            tick();
        end
        a_coin_ready = 1'b1;
        chk("p6_coin0", a_coin_value, 32'd5);
        tick();
        chk("p6_coin1", a_coin_value, 32'd1);
        tick();
        chk("p6_done", 32'(a_done), 32'd1);
        chk("p6_paid", a_paid_total, 32'd6);
        chk("p6_five", 32'(a_five_left), 32'd14);
        tick();

        // zero change: straight to done, no coin
        a_change_valid = 1'b1; a_change_amount = 32'd0;
        tick();
        a_change_valid = 1'b0;
        chk("p0_done", 32'(a_done), 32'd1);
        chk("p0_cvalid", 32'(a_coin_valid), 32'd0);
        chk("p0_paid", a_paid_total, 32'd0);
        tick();
        chk("p0_done_low", 32'(a_done), 32'd0);

        // request during PAY must be ignored
        a_change_valid = 1'b1; a_change_amount = 32'd3;
        tick();
        a_change_valid = 1'b1; a_change_amount = 32'd50;
        chk("p3_coin0", a_coin_value, 32'd1);
        tick();
        a_change_valid = 1'b0;
        chk("p3_coin1", a_coin_value, 32'd1);
        tick();
        chk("p3_coin2", a_coin_value, 32'd1);
        tick();
        chk("p3_done", 32'(a_done), 32'd1);
        chk("p3_paid", a_paid_total, 32'd3);
        tick();
        chk("p3_no_second", 32'(a_coin_valid), 32'd0);
        tick();
        chk("p3_still_idle", 32'(a_coin_valid), 32'd0);
        chk("p3_ten", 32'(a_ten_left), 32'd14);
        chk("p3_paid_hold", a_paid_total, 32'd3);

        // reset after two coins of 26 aborts and reloads stock
        a_change_valid = 1'b1; a_change_amount = 32'd26;
        tick();
        a_change_valid = 1'b0;
        chk("ab_coin0", a_coin_value, 32'd10);
        tick();
        chk("ab_coin1", a_coin_value, 32'd10);
        tick();
        chk("ab_coin2", a_coin_value, 32'd5);
        reset = 1'b0;
        #1;
        chk("ab_cvalid", 32'(a_coin_valid), 32'd0);
        chk("ab_ten", 32'(a_ten_left), 32'd16);
        chk("ab_five", 32'(a_five_left), 32'd16);
        chk("ab_paid", a_paid_total, 32'd0);
        chk("ab_ready", 32'(a_change_ready), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        a_change_valid = 1'b1; a_change_amount = 32'd15;
        tick();
        a_change_valid = 1'b0;
        chk("p15_coin0", a_coin_value, 32'd10);
        tick();
        chk("p15_coin1", a_coin_value, 32'd5);
        tick();
        chk("p15_done", 32'(a_done), 32'd1);
        chk("p15_paid", a_paid_total, 32'd15);
        chk("p15_ten", 32'(a_ten_left), 32'd15);
        chk("p15_five", 32'(a_five_left), 32'd15);

        // one ten coin in stock: 25 -> 10,5,5,5 then 12 -> 5,5,1,1
        b_change_valid = 1'b1; b_change_amount = 32'd25; b_coin_ready = 1'b1;
        tick();
        b_change_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b25_coin%0d", i), b_coin_value, 32'(c25[i]));
            tick();
        end
        chk("b25_done", 32'(b_done), 32'd1);
        chk("b25_paid", b_paid_total, 32'd25);
        chk("b25_ten", 32'(b_ten_left), 32'd0);
        chk("b25_five", 32'(b_five_left), 32'd13);
        tick();
        b_change_valid = 1'b1; b_change_amount = 32'd12;
        tick();
        b_change_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b12_coin%0d", i), b_coin_value, 32'(c12[i]));
            tick();
        end
        chk("b12_done", 32'(b_done), 32'd1);
        chk("b12_paid", b_paid_total, 32'd12);
        chk("b12_ten", 32'(b_ten_left), 32'd0);
        chk("b12_five", 32'(b_five_left), 32'd11);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
